sha256_msg_padder: RTL and testbench
====================================

Name: sha256_msg_padder

Overview:
- Upstream stage of the SHA-256 compute core.
- Accepts a byte-serial message and builds FIPS 180-4 padded 512-bit blocks: 0x80 marker, zero fill, 64-bit big-endian bit length.
- Presents each block on `block` with a one-cycle `tick` (non-last block) or `final` (last block) strobe.
- Holds the block stable until the core's `done` pulse, then builds the next block.

Parameters:
- LEN_W, 64: width of the internal message bit-length counter. Range 16..64. Zero-extended into the 64-bit length field.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_data byte offered
- in_data  input  8  message byte; first byte of a block lands in block[511:504]
- in_last  input  1  qualifies the accepted byte as the last message byte
- msg_empty  input  1  pulse: hash a zero-length message
- in_ready  output  1  byte accepted when in_valid && in_ready
- block  output  512  padded block to the core
- tick  output  1  one-cycle strobe, non-last block valid
- final  output  1  one-cycle strobe, last block valid
- done  input  1  core finished the current block
- busy  output  1  high from first accepted byte or msg_empty until done for the final block

Behaviour:
- Reset: one clk, rst=1. Afterwards:
  - block=0, tick=0, final=0, busy=0, in_ready=1.
  - Byte count n=0, bit length=0, state FILL, pend=0.
- Reset mid-operation aborts everything with no strobe. A `done` arriving later is ignored.
- Interface: one clock, synchronous active-high reset (`clk`, `rst`).
- States: FILL, ISSUE, WAIT.
- FILL (in_ready=1):
  - Each accepted byte is written to byte index n (bits 511-8n : 504-8n); n increments; bitlen increments by 8 (mod 2^LEN_W).
  - Accepted with in_last=0 and new n=64: go to ISSUE with kind=tick; pend=0.
  - Accepted with in_last=1, new n<=55:
    - byte n = 0x80; bytes n+1..55 = 0.
    - bytes 56..63 = bitlen (including this byte), zero-extended, big-endian.
    - kind=final; go to ISSUE.
  - Accepted with in_last=1, 56<=n<=63: 0x80 at n, zeros to byte 63; kind=tick; pend=LENBLK; go to ISSUE.
  - Accepted with in_last=1, n=64: kind=tick; pend=PADBLK; go to ISSUE.
  - msg_empty in FILL with n=0 and no byte accepted this cycle: block = 0x80 followed by zeros, length 0; kind=final.
  - msg_empty when n!=0 is ignored.
  - msg_empty and an accepted byte in the same cycle: the byte wins, msg_empty is ignored.
- ISSUE (in_ready=0): exactly one cycle with tick or final high per kind. Go to WAIT.
  - Latency: byte or msg_empty accepted on edge T → strobe high in the cycle after T+1's edge, i.e. one cycle after acceptance.
- WAIT (in_ready=0): block is held; `done` is sampled.
  - done, pend=LENBLK: block = zeros bytes 0..55, length in bytes 56..63; kind=final; pend=0; go to ISSUE.
  - done, pend=PADBLK: block = 0x80, zeros, length; kind=final; pend=0; go to ISSUE.
  - done after a final block: clear n, bitlen and block; busy=0; go to FILL.
  - done after a non-final block: clear n and the block buffer, keep bitlen; go to FILL.
- `done` outside WAIT is ignored.
- in_valid while in_ready=0 is not accepted; the upstream holds it.
- The bit counter wraps modulo 2^LEN_W silently.

Optional Feature:
- SHA256_PAD_LEN_OVF_EN defined:
  - Adds output `len_ovf` (1 bit).
  - Set sticky when bitlen wraps.
  - Cleared on rst and on transition to FILL after a final block.
  - While set, the final-block length field is forced to all ones.
- Undefined: no `len_ovf` port; wrap is silent and the length field holds bitlen mod 2^LEN_W.

Test Plan:
- "abc": bytes 0x61, 0x62, 0x63 (last on 0x63).
  - final strobe one cycle after the 0x63 accept.
  - block = 0x61626380, then zeros, low 64 bits = 0x18.
  - After done: in_ready=1, busy=0.
- msg_empty pulse: final strobe; block = 0x80 followed by 62 zero bytes then 0x00.
  - Low 64 bits = 0.
- 56 bytes 0x61 (last):
  - First block: tick strobe; byte 56 = 0x80, bytes 57..63 = 0.
  - After done: final block of zeros with low 64 bits = 0x1C0.
- 64 bytes 0x00 (last):
  - tick strobe with an all-zero block.
  - After done: final block = 0x80 then zeros, length 0x200.
  - Check in_ready=0 from the accept until done.
- 65-byte message: tick after byte 64, then in_ready=0.
  - in_valid held high during WAIT; the byte is accepted only after done.
  - Final block has length 0x208.
- rst asserted during WAIT: outputs return to reset values the next cycle.
  - A later done pulse produces no strobe.
  - A new "abc" hashes correctly.

Source files
------------

// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: byte-serial FIPS 180-4 padder producing 512-bit blocks for the SHA-256 core.
// Define SHA256_PAD_LEN_OVF_EN to add the sticky len_ovf output (forces an all-ones length field).
module sha256_msg_padder #(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  input  logic         msg_empty,
  output logic         in_ready,
  output logic [511:0] block,
  output logic         tick,
  output logic         final_blk,
  input  logic         done,
  output logic         busy
`ifdef SHA256_PAD_LEN_OVF_EN
  ,
  output logic         len_ovf
`endif
);
  typedef enum logic [1:0] {FILL, ISSUE, WAIT} state_t;
  typedef enum logic [1:0] {P_NONE, P_LEN, P_PAD} pend_t;
  state_t state;
  pend_t pend;
  logic kind;
  logic [6:0] n, n_nxt;
  logic [LEN_W-1:0] bitlen, bl_nxt;
  logic ovf, ovf_nxt, take;
  logic [511:0] put, mark;
  logic [63:0] len_take, len_hold;
  assign in_ready = state == FILL;
  assign take = in_ready && in_valid;
  assign n_nxt = n + 7'd1;
  assign bl_nxt = bitlen + LEN_W'(8);
  // Bytes past n are always zero, so new bytes and the marker can simply be OR-ed in.
  assign put = {in_data, 504'b0} >> {n, 3'b0};
  assign mark = {8'h80, 504'b0} >> {n_nxt, 3'b0};
`ifdef SHA256_PAD_LEN_OVF_EN
  assign ovf_nxt = ovf | (bl_nxt < bitlen);
  assign len_ovf = ovf;
`else
  assign ovf = 1'b0;
  assign ovf_nxt = 1'b0;
`endif
  assign len_take = ovf_nxt ? '1 : 64'(bl_nxt);
  assign len_hold = ovf ? '1 : 64'(bitlen);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      pend <= P_NONE;
      kind <= 1'b0;
      n <= '0;
      bitlen <= '0;
      block <= '0;
      tick <= 1'b0;
      final_blk <= 1'b0;
      busy <= 1'b0;
`ifdef SHA256_PAD_LEN_OVF_EN
      ovf <= 1'b0;
`endif
    end else begin
      tick <= 1'b0;
      final_blk <= 1'b0;
      case (state)
        FILL: begin
          if (take) begin
            n <= n_nxt;
            bitlen <= bl_nxt;
            busy <= 1'b1;
`ifdef SHA256_PAD_LEN_OVF_EN
            ovf <= ovf_nxt;
`endif
            if (in_last && n_nxt <= 7'd55) begin
              block <= block | put | mark | {448'b0, len_take};
              kind <= 1'b1;
              state <= ISSUE;
            end else if (in_last) begin
              block <= block | put | mark;
              kind <= 1'b0;
              pend <= (n_nxt == 7'd64) ? P_PAD : P_LEN;
              state <= ISSUE;
            end else if (n_nxt == 7'd64) begin
              block <= block | put;
              kind <= 1'b0;
              pend <= P_NONE;
              state <= ISSUE;
            end else begin
              block <= block | put;
            end
          end else if (msg_empty && n == 7'd0) begin
            block <= {8'h80, 504'b0};
            kind <= 1'b1;
            busy <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          tick <= !kind;
          final_blk <= kind;
          state <= WAIT;
        end
        WAIT: begin
          if (done) begin
            if (pend != P_NONE) begin
              block <= ((pend == P_PAD) ? {8'h80, 504'b0} : 512'b0) | {448'b0, len_hold};
              kind <= 1'b1;
              pend <= P_NONE;
              state <= ISSUE;
            end else begin
              n <= '0;
              block <= '0;
              state <= FILL;
              if (kind) begin
                bitlen <= '0;
                busy <= 1'b0;
`ifdef SHA256_PAD_LEN_OVF_EN
                ovf <= 1'b0;
`endif
              end
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb_sha256_msg_padder: directed self-checking bench for sha256_msg_padder.
module tb_sha256_msg_padder;
  logic clk = 0, rst = 0, in_valid = 0, in_last = 0, msg_empty = 0, done = 0;
  logic [7:0] in_data = 0;
  logic in_ready, tick, final_blk, busy;
  logic [511:0] block;
  int n_cmp = 0, n_bad = 0;
`ifdef SHA256_PAD_LEN_OVF_EN
  logic len_ovf;
`endif
  sha256_msg_padder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .msg_empty(msg_empty), .in_ready(in_ready), .block(block), .tick(tick),
    .final_blk(final_blk), .done(done), .busy(busy)
`ifdef SHA256_PAD_LEN_OVF_EN
    , .len_ovf(len_ovf)
`endif
  );
  always #5 clk = ~clk;
  task step;
    @(posedge clk);
    #1;
  endtask
  task send(input logic [7:0] d, input logic last);
    in_valid = 1; in_data = d; in_last = last;
    step;
    in_valid = 0; in_last = 0;
  endtask
  task pulse_done;
    done = 1;
    step;
    done = 0;
  endtask
  task test_reset;
    rst = 1;
    step;
    rst = 0;
    n_cmp++;
    if (block !== 512'b0 || tick !== 0 || final_blk !== 0 || busy !== 0 || in_ready !== 1) begin
      n_bad++;
      $display("FAIL reset: block=%h tick=%b final=%b busy=%b ready=%b", block, tick, final_blk, busy, in_ready);
    end
  endtask
  task test_abc(input string tag);
    logic [511:0] exp_b;
    exp_b = {32'h61626380, 416'b0, 64'h18};
    send(8'h61, 0); send(8'h62, 0); send(8'h63, 1);
    n_cmp++;
    if (final_blk !== 0 || in_ready !== 0 || busy !== 1) begin
      n_bad++; $display("FAIL %s_issue: final=%b ready=%b busy=%b want 0 0 1", tag, final_blk, in_ready, busy);
    end
    step;
    n_cmp++;
    if (final_blk !== 1 || tick !== 0 || block !== exp_b) begin
      n_bad++; $display("FAIL %s_final: final=%b tick=%b block=%h want %h", tag, final_blk, tick, block, exp_b);
    end
    step;
    n_cmp++;
    if (final_blk !== 0 || block !== exp_b) begin
      n_bad++; $display("FAIL %s_hold: final=%b block=%h", tag, final_blk, block);
    end
    pulse_done;
    n_cmp++;
    if (in_ready !== 1 || busy !== 0 || block !== 512'b0) begin
      n_bad++; $display("FAIL %s_done: ready=%b busy=%b block=%h want 1 0 0", tag, in_ready, busy, block);
    end
  endtask
  task test_empty;
    msg_empty = 1;
    step;
    msg_empty = 0;
    n_cmp++;
    if (busy !== 1 || in_ready !== 0) begin
      n_bad++; $display("FAIL empty_accept: busy=%b ready=%b want 1 0", busy, in_ready);
    end
    step;
    n_cmp++;
    if (final_blk !== 1 || block !== {8'h80, 504'b0}) begin
      n_bad++; $display("FAIL empty_final: final=%b block=%h", final_blk, block);
    end
    pulse_done;
    n_cmp++;
    if (in_ready !== 1 || busy !== 0) begin
      n_bad++; $display("FAIL empty_done: ready=%b busy=%b want 1 0", in_ready, busy);
    end
  endtask
  task test_56;
    logic [511:0] exp_b;
    for (int i = 0; i < 56; i++) send(8'h61, i == 55);
    step;
    exp_b = {{56{8'h61}}, 8'h80, 56'b0};
    n_cmp++;
    if (tick !== 1 || final_blk !== 0 || block !== exp_b) begin
      n_bad++; $display("FAIL b56_tick: tick=%b final=%b block=%h want %h", tick, final_blk, block, exp_b);
    end
    step;
    pulse_done;
    step;
    n_cmp++;
    if (final_blk !== 1 || tick !== 0 || block !== {448'b0, 64'h1C0}) begin
      n_bad++; $display("FAIL b56_final: final=%b tick=%b block=%h", final_blk, tick, block);
    end
    pulse_done;
    n_cmp++;
    if (in_ready !== 1 || busy !== 0) begin
      n_bad++; $display("FAIL b56_done: ready=%b busy=%b want 1 0", in_ready, busy);
    end
  endtask
  task test_64;
    for (int i = 0; i < 64; i++) send(8'h00, i == 63);
    n_cmp++;
    if (in_ready !== 0) begin
      n_bad++; $display("FAIL b64_ready_accept: ready=%b want 0", in_ready);
    end
    step;
    n_cmp++;
    if (tick !== 1 || final_blk !== 0 || block !== 512'b0 || in_ready !== 0) begin
      n_bad++; $display("FAIL b64_tick: tick=%b final=%b ready=%b block=%h", tick, final_blk, in_ready, block);
    end
    step; step;
    n_cmp++;
    if (in_ready !== 0 || tick !== 0) begin
      n_bad++; $display("FAIL b64_wait: ready=%b tick=%b want 0 0", in_ready, tick);
    end
    pulse_done;
    n_cmp++;
    if (in_ready !== 0) begin
      n_bad++; $display("FAIL b64_ready_pad: ready=%b want 0", in_ready);
    end
    step;
    n_cmp++;
    if (final_blk !== 1 || block !== {8'h80, 440'b0, 64'h200}) begin
      n_bad++; $display("FAIL b64_final: final=%b block=%h", final_blk, block);
    end
    pulse_done;
    n_cmp++;
    if (in_ready !== 1 || busy !== 0) begin
      n_bad++; $display("FAIL b64_done: ready=%b busy=%b want 1 0", in_ready, busy);
    end
  endtask
  task test_back_to_back;
    for (int i = 0; i < 64; i++) send(8'h5A, 0);
    in_valid = 1; in_data = 8'h5B; in_last = 1;
    step;
    n_cmp++;
    if (tick !== 1 || block !== {64{8'h5A}} || in_ready !== 0) begin
      n_bad++; $display("FAIL b65_tick: tick=%b ready=%b block=%h", tick, in_ready, block);
    end
    step; step;
    n_cmp++;
    if (in_ready !== 0 || block !== {64{8'h5A}}) begin
      n_bad++; $display("FAIL b65_held: ready=%b block=%h", in_ready, block);
    end
    pulse_done;
    n_cmp++;
    if (in_ready !== 1 || block !== 512'b0 || busy !== 1) begin
      n_bad++; $display("FAIL b65_refill: ready=%b busy=%b block=%h want 1 1 0", in_ready, busy, block);
    end
    step;
    in_valid = 0; in_last = 0;
    n_cmp++;
    if (in_ready !== 0) begin
      n_bad++; $display("FAIL b65_accept: ready=%b want 0", in_ready);
    end
    step;
    n_cmp++;
    if (final_blk !== 1 || block !== {8'h5B, 8'h80, 432'b0, 64'h208}) begin
      n_bad++; $display("FAIL b65_final: final=%b block=%h", final_blk, block);
    end
    pulse_done;
    n_cmp++;
    if (in_ready !== 1 || busy !== 0) begin
      n_bad++; $display("FAIL b65_done: ready=%b busy=%b want 1 0", in_ready, busy);
    end
  endtask
  task test_reset_wait;
    send(8'h61, 1);
    step; step;
    n_cmp++;
    if (in_ready !== 0 || busy !== 1) begin
      n_bad++; $display("FAIL rstw_pre: ready=%b busy=%b want 0 1", in_ready, busy);
    end
    rst = 1;
    step;
    rst = 0;
    n_cmp++;
    if (block !== 512'b0 || tick !== 0 || final_blk !== 0 || busy !== 0 || in_ready !== 1) begin
      n_bad++; $display("FAIL rstw_reset: block=%h tick=%b final=%b busy=%b ready=%b", block, tick, final_blk, busy, in_ready);
    end
    pulse_done;
    step;
    n_cmp++;
    if (tick !== 0 || final_blk !== 0 || in_ready !== 1 || busy !== 0) begin
      n_bad++; $display("FAIL rstw_late_done: tick=%b final=%b ready=%b busy=%b", tick, final_blk, in_ready, busy);
    end
    test_abc("abc2");
  endtask
  initial begin
    test_reset;
    test_abc("abc");
    test_empty;
    test_56;
    test_64;
    test_back_to_back;
    test_reset_wait;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
